// File: rtl/checker_pkg.sv
// Shared constants for the result checker: FSM encoding and counter sizing.
package checker_pkg;

  // FSM state encoding
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  // Default width of the sample/error/index counters
  localparam int CNT_W_DEF = 16;

  // Value at which a default-width counter stops incrementing
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment; increment is suppressed once at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/result_checker.sv
// Compares datapath results against a reference over a bounded run, counting
// samples and mismatches and latching the first failing pair.
module result_checker
  import checker_pkg::*;
#(
  parameter int          N           = 8,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned LIMIT       = 256,
  parameter bit          STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             valid,
  input  logic [N-1:0]     q_dut,
  input  logic [N-1:0]     q_ref,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             error,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_idx,
  output logic [N-1:0]     first_dut,
  output logic [N-1:0]     first_ref
);

  // Count value held just before the sample that completes the run.
  localparam logic [CNT_W-1:0] LAST_CNT = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       in_run;
  logic       start_run;
  logic       accept;
  logic       mismatch;
  logic       hit_limit;
  logic       end_run;

  assign in_run    = (state == RUN);
  // start is only honoured outside a run; the same edge clears all results
  assign start_run = start && !in_run;
  // samples on the start edge are ignored since state is not yet RUN
  assign accept    = in_run && valid;
  assign mismatch  = accept && (q_dut != q_ref);
  assign hit_limit = (LIMIT != 0) && accept && (sample_cnt == LAST_CNT);
  assign end_run   = in_run && (hit_limit || (STOP_ON_ERR && mismatch) || abort);

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign pass = done && !error;

  // Next-state selection for the IDLE/RUN/DONE controller.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start_run) state_nxt = RUN;
      RUN:     if (end_run)   state_nxt = DONE;
      DONE:    if (start_run) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Sticky error flag and first-mismatch capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error     <= 1'b0;
      first_idx <= '0;
      first_dut <= '0;
      first_ref <= '0;
    end else if (start_run) begin
      error     <= 1'b0;
      first_idx <= '0;
      first_dut <= '0;
      first_ref <= '0;
    end else if (mismatch) begin
      error <= 1'b1;
      if (!error) begin
        first_idx <= sample_cnt;
        first_dut <= q_dut;
        first_ref <= q_ref;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_sample_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_run),
    .inc   (accept),
    .q     (sample_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_run),
    .inc   (mismatch),
    .q     (err_cnt)
  );

endmodule

// File: tb/tb_result_checker.sv
// Scoreboard bench for result_checker: three configurations share one stimulus
// stream; a behavioural model predicts each one's outputs every cycle.
module tb_result_checker;
  import checker_pkg::*;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        pass;
    logic        error;
    logic [15:0] sc;
    logic [15:0] ec;
    logic [15:0] fi;
    logic [7:0]  fd;
    logic [7:0]  fr;
  } out_t;

  typedef struct {
    int   inst;
    out_t exp;
  } sb_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] q_dut = '0;
  logic [7:0] q_ref = '0;

  logic        busy_w [3];
  logic        done_w [3];
  logic        pass_w [3];
  logic        error_w[3];
  logic [15:0] sc_w   [3];
  logic [15:0] ec_w   [3];
  logic [15:0] fi_w   [3];
  logic [7:0]  fd_w   [3];
  logic [7:0]  fr_w   [3];

  int checks = 0;
  int errors = 0;

  // configurations: 0 = LIMIT 4, 1 = LIMIT 8, 2 = LIMIT 4 with stop-on-error
  int unsigned cfg_limit[3] = '{4, 8, 4};
  bit          cfg_stop [3] = '{1'b0, 1'b0, 1'b1};

  int unsigned m_st[3];
  int unsigned m_sc[3];
  int unsigned m_ec[3];
  int unsigned m_fi[3];
  bit          m_err[3];
  logic [7:0]  m_fd[3];
  logic [7:0]  m_fr[3];

  sb_t sb_q[$];

  always #5 clk = ~clk;

  result_checker #(.N(8), .CNT_W(16), .LIMIT(4), .STOP_ON_ERR(1'b0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid(valid),
    .q_dut(q_dut), .q_ref(q_ref), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .error(error_w[0]), .sample_cnt(sc_w[0]), .err_cnt(ec_w[0]),
    .first_idx(fi_w[0]), .first_dut(fd_w[0]), .first_ref(fr_w[0])
  );

  result_checker #(.N(8), .CNT_W(16), .LIMIT(8), .STOP_ON_ERR(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid(valid),
    .q_dut(q_dut), .q_ref(q_ref), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .error(error_w[1]), .sample_cnt(sc_w[1]), .err_cnt(ec_w[1]),
    .first_idx(fi_w[1]), .first_dut(fd_w[1]), .first_ref(fr_w[1])
  );

  result_checker #(.N(8), .CNT_W(16), .LIMIT(4), .STOP_ON_ERR(1'b1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .valid(valid),
    .q_dut(q_dut), .q_ref(q_ref), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .error(error_w[2]), .sample_cnt(sc_w[2]), .err_cnt(ec_w[2]),
    .first_idx(fi_w[2]), .first_dut(fd_w[2]), .first_ref(fr_w[2])
  );

  function automatic out_t obs_out(input int i);
    out_t o;
    o.busy  = busy_w[i];
    o.done  = done_w[i];
    o.pass  = pass_w[i];
    o.error = error_w[i];
    o.sc    = sc_w[i];
    o.ec    = ec_w[i];
    o.fi    = fi_w[i];
    o.fd    = fd_w[i];
    o.fr    = fr_w[i];
    return o;
  endfunction

  function automatic out_t model_out(input int i);
    out_t o;
    o.busy  = (m_st[i] == 1);
    o.done  = (m_st[i] == 2);
    o.pass  = (m_st[i] == 2) && !m_err[i];
    o.error = m_err[i];
    o.sc    = 16'(m_sc[i]);
    o.ec    = 16'(m_ec[i]);
    o.fi    = 16'(m_fi[i]);
    o.fd    = m_fd[i];
    o.fr    = m_fr[i];
    return o;
  endfunction

  function automatic void model_clear(input int i);
    m_sc[i]  = 0;
    m_ec[i]  = 0;
    m_fi[i]  = 0;
    m_err[i] = 1'b0;
    m_fd[i]  = '0;
    m_fr[i]  = '0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0;
      model_clear(i);
    end
    sb_q.delete();
  endfunction

  // Behavioural prediction of one rising edge for configuration i.
  function automatic void model_step(input int i, input bit s, input bit a, input bit v,
                                     input logic [7:0] d, input logic [7:0] r);
    bit bad;
    bad = v && (d != r);
    if (m_st[i] != 1) begin
      if (s) begin
        model_clear(i);
        m_st[i] = 1;
      end
    end else begin
      if (v) begin
        if (bad) begin
          if (!m_err[i]) begin
            m_fi[i] = m_sc[i];
            m_fd[i] = d;
            m_fr[i] = r;
          end
          m_err[i] = 1'b1;
          if (m_ec[i] != CNT_MAX) m_ec[i] = m_ec[i] + 1;
        end
        m_sc[i] = m_sc[i] + 1;
      end
      if ((cfg_limit[i] != 0 && v && m_sc[i] == cfg_limit[i]) || (cfg_stop[i] && bad) || a)
        m_st[i] = 2;
    end
  endfunction

  // Drive one cycle of stimulus, predict, then drain the scoreboard after the edge.
  task automatic step(input bit s, input bit a, input bit v,
                      input logic [7:0] d, input logic [7:0] r);
    sb_t e;
    out_t got;
    @(negedge clk);
    start = s; abort = a; valid = v; q_dut = d; q_ref = r;
    for (int i = 0; i < 3; i++) begin
      model_step(i, s, a, v, d, r);
      e.inst = i;
      e.exp  = model_out(i);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      got = obs_out(e.inst);
      checks++;
      if (got !== e.exp) begin
        errors++;
        $display("FAIL scoreboard inst%0d t=%0t: got %h expected %h", e.inst, $time, got, e.exp);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; valid = 1'b0; q_dut = '0; q_ref = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_out(i) !== '0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got %h expected 0", i, obs_out(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    // idle traffic: toggling valid with mismatched data, plus a stray abort
    for (int k = 0; k < 6; k++) step(1'b0, k == 3, k[0], 8'hAA, 8'h55);
    checks++;
    if (sc_w[0] !== 16'd0 || busy_w[0] !== 1'b0 || error_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore: got sc=%0d busy=%b error=%b done=%b expected 0 0 0 0",
               sc_w[0], busy_w[0], error_w[0], done_w[0]);
    end
  endtask

  task automatic test_clean_run();
    do_reset();
    step(1'b1, 1'b0, 1'b1, 8'h00, 8'hFF);  // valid on start edge is ignored
    for (int k = 1; k <= 4; k++) step(1'b0, 1'b0, 1'b1, 8'(k), 8'(k));
    checks++;
    if (done_w[0] !== 1'b1 || pass_w[0] !== 1'b1 || sc_w[0] !== 16'd4 || ec_w[0] !== 16'd0) begin
      errors++;
      $display("FAIL clean_run: got done=%b pass=%b sc=%0d ec=%0d expected 1 1 4 0",
               done_w[0], pass_w[0], sc_w[0], ec_w[0]);
    end
    // DONE holds its verdict against later traffic
    step(1'b0, 1'b1, 1'b1, 8'h01, 8'h02);
    checks++;
    if (done_w[0] !== 1'b1 || sc_w[0] !== 16'd4 || ec_w[0] !== 16'd0) begin
      errors++;
      $display("FAIL done_hold: got done=%b sc=%0d ec=%0d expected 1 4 0",
               done_w[0], sc_w[0], ec_w[0]);
    end
  endtask

  task automatic test_mismatch_capture();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h01, 8'h01);
    step(1'b0, 1'b0, 1'b1, 8'h02, 8'h02);
    step(1'b0, 1'b0, 1'b1, 8'h5A, 8'h5B);
    step(1'b0, 1'b0, 1'b1, 8'h11, 8'h22);
    checks++;
    if (ec_w[0] !== 16'd2 || fi_w[0] !== 16'd2 || fd_w[0] !== 8'h5A || fr_w[0] !== 8'h5B) begin
      errors++;
      $display("FAIL mismatch_capture: got ec=%0d idx=%0d dut=%h ref=%h expected 2 2 5a 5b",
               ec_w[0], fi_w[0], fd_w[0], fr_w[0]);
    end
    checks++;
    if (pass_w[0] !== 1'b0 || error_w[0] !== 1'b1 || done_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_verdict: got pass=%b error=%b done=%b expected 0 1 1",
               pass_w[0], error_w[0], done_w[0]);
    end
  endtask

  task automatic test_stop_on_err();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h07, 8'h07);
    step(1'b0, 1'b0, 1'b1, 8'h08, 8'h09);
    checks++;
    if (done_w[2] !== 1'b1 || sc_w[2] !== 16'd2 || fi_w[2] !== 16'd1) begin
      errors++;
      $display("FAIL stop_on_err: got done=%b sc=%0d idx=%0d expected 1 2 1",
               done_w[2], sc_w[2], fi_w[2]);
    end
    step(1'b0, 1'b0, 1'b1, 8'h03, 8'h04);
    step(1'b0, 1'b0, 1'b1, 8'h05, 8'h06);
    checks++;
    if (sc_w[2] !== 16'd2 || ec_w[2] !== 16'd1) begin
      errors++;
      $display("FAIL stop_frozen: got sc=%0d ec=%0d expected 2 1", sc_w[2], ec_w[2]);
    end
  endtask

  task automatic test_abort_restart();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h01, 8'h01);
    step(1'b0, 1'b0, 1'b1, 8'h02, 8'h03);
    step(1'b0, 1'b1, 1'b1, 8'h03, 8'h03);
    checks++;
    if (sc_w[1] !== 16'd3 || done_w[1] !== 1'b1 || busy_w[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort: got sc=%0d done=%b busy=%b expected 3 1 0",
               sc_w[1], done_w[1], busy_w[1]);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (busy_w[1] !== 1'b1 || sc_w[1] !== 16'd0 || ec_w[1] !== 16'd0 || error_w[1] !== 1'b0 ||
        fi_w[1] !== 16'd0 || fd_w[1] !== 8'h00 || fr_w[1] !== 8'h00) begin
      errors++;
      $display("FAIL restart_clear: got busy=%b sc=%0d ec=%0d err=%b idx=%0d expected 1 0 0 0 0",
               busy_w[1], sc_w[1], ec_w[1], error_w[1], fi_w[1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] r;
    int bad;
    bad = 0;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      r = ($urandom_range(0, 2) == 0) ? (d ^ 8'h80) : d;
      if (d != r) bad++;
      step(1'b0, 1'b0, 1'b1, d, r);
    end
    checks++;
    if (done_w[1] !== 1'b1 || sc_w[1] !== 16'd8 || ec_w[1] !== 16'(bad) || pass_w[1] !== (bad == 0)) begin
      errors++;
      $display("FAIL back_to_back: got done=%b sc=%0d ec=%0d pass=%b expected 1 8 %0d %b",
               done_w[1], sc_w[1], ec_w[1], pass_w[1], bad, bad == 0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h10, 8'h10);
    step(1'b0, 1'b0, 1'b1, 8'h20, 8'h21);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs_out(i) !== '0) begin
        errors++;
        $display("FAIL async_reset inst%0d: got %h expected 0", i, obs_out(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b1, 8'h05, 8'h06);
    step(1'b0, 1'b0, 1'b1, 8'h07, 8'h07);
    checks++;
    if (busy_w[0] !== 1'b0 || sc_w[0] !== 16'd0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b sc=%0d expected 0 0", busy_w[0], sc_w[0]);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checks++;
    if (busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL resume_start: got busy=%b expected 1", busy_w[0]);
    end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_mismatch_capture();
    test_stop_on_err();
    test_abort_restart();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
